// File: rtl/vit_patch_pkg.sv
// Shared definitions for the ViT patch front end: pixel geometry, patchifier
// state encodings and the loader FSM states.
package vit_patch_pkg;

  localparam int CHANNEL_SIZE = 8;
  localparam int NUM_CHANNELS = 3;
  localparam int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int PATCH_SIZE   = 8;

  localparam logic [1:0] PF_IDLE       = 2'b00;
  localparam logic [1:0] PF_PROCESSING = 2'b10;
  localparam logic [1:0] PF_DONE       = 2'b11;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT_ACK
  } load_state_e;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/patch_band_buffer.sv
// One band of PATCH_SIZE image rows held in registers, written one pixel at a
// time and read out as a PATCH_SIZE x PATCH_SIZE tile selected by column.
module patch_band_buffer
  import vit_patch_pkg::*;
#(
  parameter int  IMG_WIDTH = 32,
  localparam int PPR       = IMG_WIDTH / PATCH_SIZE,
  localparam int COL_W     = idx_w(PPR),
  localparam int R_W       = idx_w(PATCH_SIZE),
  localparam int X_W       = idx_w(IMG_WIDTH)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                we,
  input  logic [R_W-1:0]                                      wr_row,
  input  logic [X_W-1:0]                                      wr_col,
  input  logic [PIXEL_WIDTH-1:0]                              wr_data,
  input  logic [COL_W-1:0]                                    rd_col,
  output logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] tile
);

  pixel_t band_q [PATCH_SIZE][IMG_WIDTH];
  pixel_t band_d [PATCH_SIZE][IMG_WIDTH];

  always_comb begin
    band_d = band_q;
    if (we) begin
      band_d[wr_row][wr_col] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      band_q <= '{default: '0};
    end else begin
      band_q <= band_d;
    end
  end

  // Tile column j of the selected patch lives at image column rd_col*PATCH_SIZE+j.
  always_comb begin
    tile = '0;
    for (int i = 0; i < PATCH_SIZE; i++) begin
      for (int j = 0; j < PATCH_SIZE; j++) begin
        tile[i][j] = band_q[i][int'(rd_col) * PATCH_SIZE + j];
      end
    end
  end

endmodule

// File: rtl/patch_band_loader.sv
// Buffers a band of raster pixels, then hands each tile of that band to the
// patchifier with a one-cycle en pulse, tagging it with its patch row/column.
module patch_band_loader
  import vit_patch_pkg::*;
#(
  parameter int  IMG_WIDTH  = 32,
  parameter int  IMG_HEIGHT = 32,
  localparam int PPR        = IMG_WIDTH / PATCH_SIZE,
  localparam int PPC        = IMG_HEIGHT / PATCH_SIZE,
  localparam int ROW_W      = idx_w(PPC),
  localparam int COL_W      = idx_w(PPR)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                pix_valid,
  input  logic [PIXEL_WIDTH-1:0]                              pix_data,
  output logic                                                pix_ready,
  input  logic [1:0]                                          pf_state,
  output logic                                                en,
  output logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] patch_cache,
  output logic [ROW_W-1:0]                                    patch_row,
  output logic [COL_W-1:0]                                    patch_col,
  output logic                                                frame_done
);

  localparam int R_W = idx_w(PATCH_SIZE);
  localparam int X_W = idx_w(IMG_WIDTH);

  localparam logic [R_W-1:0]   R_LAST    = R_W'(PATCH_SIZE - 1);
  localparam logic [X_W-1:0]   C_LAST    = X_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] PCOL_LAST = COL_W'(PPR - 1);
  localparam logic [ROW_W-1:0] PROW_LAST = ROW_W'(PPC - 1);

  load_state_e      state_q, state_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [X_W-1:0]   c_q, c_d;
  logic [ROW_W-1:0] patch_row_q, patch_row_d;
  logic [COL_W-1:0] patch_col_q, patch_col_d;
  logic             frame_done_q, frame_done_d;
  logic             armed_q, armed_d;
  logic             accept;

  // armed_q keeps pix_ready low for the first cycle after reset is released.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    patch_row_d  = patch_row_q;
    patch_col_d  = patch_col_q;
    frame_done_d = 1'b0;
    armed_d      = 1'b1;
    en           = 1'b0;
    accept       = 1'b0;
    pix_ready    = (state_q == ST_FILL) && armed_q && !reset;

    case (state_q)
      ST_FILL: begin
        if (pix_valid && pix_ready) begin
          accept = 1'b1;
          if (c_q == C_LAST) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              r_d     = '0;
              state_d = ST_ISSUE;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if ((pf_state == PF_IDLE) && !reset) begin
          en      = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Leaving only once the patchifier looks busy prevents a double start.
        if (pf_state != PF_IDLE) begin
          if (patch_col_q != PCOL_LAST) begin
            patch_col_d = patch_col_q + 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            patch_col_d = '0;
            state_d     = ST_FILL;
            if (patch_row_q == PROW_LAST) begin
              patch_row_d  = '0;
              frame_done_d = 1'b1;
            end else begin
              patch_row_d = patch_row_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      r_q          <= '0;
      c_q          <= '0;
      patch_row_q  <= '0;
      patch_col_q  <= '0;
      frame_done_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      patch_row_q  <= patch_row_d;
      patch_col_q  <= patch_col_d;
      frame_done_q <= frame_done_d;
      armed_q      <= armed_d;
    end
  end

  patch_band_buffer #(
    .IMG_WIDTH(IMG_WIDTH)
  ) u_band (
    .clk    (clk),
    .reset  (reset),
    .we     (accept),
    .wr_row (r_q),
    .wr_col (c_q),
    .wr_data(pix_data),
    .rd_col (patch_col_q),
    .tile   (patch_cache)
  );

  assign patch_row  = patch_row_q;
  assign patch_col  = patch_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_patch_band_loader.sv
// Bench for patch_band_loader on a 16x16 image: pixels are remembered by frame
// position and every handed-off tile is rebuilt from them and compared.
module tb_patch_band_loader;
  import vit_patch_pkg::*;

  localparam int W     = 16;
  localparam int H     = 16;
  localparam int PPR   = W / PATCH_SIZE;
  localparam int PPC   = H / PATCH_SIZE;
  localparam int TPF   = PPR * PPC;
  localparam int NPIX  = W * H;
  localparam int ROW_W = idx_w(PPC);
  localparam int COL_W = idx_w(PPR);

  typedef logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] tile_t;

  typedef struct {
    string  name;
    int     tile_num;
    int     i;
    int     j;
    pixel_t exp_pix;
    int     exp_row;
    int     exp_col;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pix_valid = 1'b0;
  logic [PIXEL_WIDTH-1:0] pix_data = '0;
  logic             pix_ready;
  logic [1:0]       pf_state = PF_IDLE;
  logic             en;
  tile_t            patch_cache;
  logic [ROW_W-1:0] patch_row;
  logic [COL_W-1:0] patch_col;
  logic             frame_done;

  patch_band_loader #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .pf_state   (pf_state),
    .en         (en),
    .patch_cache(patch_cache),
    .patch_row  (patch_row),
    .patch_col  (patch_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference state: accepted pixels by frame position plus handoff bookkeeping.
  pixel_t pix_mem [NPIX];
  int     acc_idx = 0;
  int     tile_idx = 0;
  int     cyc = 0;
  int     last_en_cyc = 0;
  bit     have_last_en = 1'b0;
  bit     nonidle_since_en = 1'b1;
  bit     en_seen = 1'b0;
  int     en_total = 0;
  int     fd_total = 0;
  int     fd_mark = -1;

  bit     pf_auto = 1'b1;
  bit     pf_rand = 1'b0;
  int     pf_hold = 10;
  int     pf_cnt = 0;

  bit     cap_on = 1'b0;
  tile_t  cap_tile [$];
  int     cap_row [$];
  int     cap_col [$];

  int     pix_mode = 0;
  int     pix_counter = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic tile_t expected_tile(input int t);
    tile_t e;
    int band, col;
    band = t / PPR;
    col  = t % PPR;
    for (int i = 0; i < PATCH_SIZE; i++)
      for (int j = 0; j < PATCH_SIZE; j++)
        e[i][j] = pix_mem[(band * PATCH_SIZE + i) * W + col * PATCH_SIZE + j];
    return e;
  endfunction

  // Handoff monitor: checks every en and frame_done against the model.
  initial begin
    int t, diffs;
    tile_t e;
    forever begin
      @(negedge clk);
      cyc++;
      en_seen = en && !reset;
      if (!reset) begin
        if (pf_state != PF_IDLE) nonidle_since_en = 1'b1;
        if (en) begin
          t = tile_idx % TPF;
          e = expected_tile(t);
          diffs = 0;
          checkOutput("en_with_idle", 64'(pf_state), 64'(PF_IDLE));
          checkOutput("en_and_ready", 64'(pix_ready), 64'd0);
          checkOutput("no_double_start", 64'(nonidle_since_en), 64'd1);
          if (have_last_en) checkOutput("en_spacing_ge2", 64'((cyc - last_en_cyc) >= 2), 64'd1);
          checkOutput("patch_row", 64'(patch_row), 64'(t / PPR));
          checkOutput("patch_col", 64'(patch_col), 64'(t % PPR));
          for (int i = 0; i < PATCH_SIZE; i++)
            for (int j = 0; j < PATCH_SIZE; j++)
              if (patch_cache[i][j] !== e[i][j]) diffs++;
          checkOutput("tile_data_bad_pixels", 64'(diffs), 64'd0);
          if (cap_on) begin
            cap_tile.push_back(patch_cache);
            cap_row.push_back(int'(patch_row));
            cap_col.push_back(int'(patch_col));
          end
          nonidle_since_en = 1'b0;
          have_last_en = 1'b1;
          last_en_cyc = cyc;
          tile_idx++;
          en_total++;
        end
        if (frame_done) begin
          checkOutput("frame_done_at_frame_end",
                      64'((tile_idx > 0) && (tile_idx % TPF == 0) && (fd_mark != tile_idx)), 64'd1);
          fd_mark = tile_idx;
          fd_total++;
        end
      end
    end
  end

  // Patchifier model: goes busy on the edge that captures en, idles after a hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pf_auto) begin
        if (en_seen) begin
          pf_cnt   = pf_rand ? int'($urandom_range(1, 5)) : pf_hold;
          pf_state = (pf_rand && $urandom_range(0, 3) == 0) ? 2'b01 : PF_PROCESSING;
        end else if (pf_cnt > 0) begin
          pf_cnt--;
          if (pf_cnt == 0) pf_state = PF_IDLE;
        end
      end
    end
  end

  // valid_mode: 0 always valid, 1 toggling 1010..., 2 random.
  task automatic applyStimulus(input int n, input int valid_mode, input int budget);
    int sent, cycles;
    bit phase;
    sent = 0;
    cycles = 0;
    phase = 1'b1;
    while (sent < n && cycles < budget) begin
      case (valid_mode)
        0:       pix_valid = 1'b1;
        1:       pix_valid = phase;
        default: pix_valid = ($urandom_range(0, 2) != 0);
      endcase
      pix_data = (pix_mode == 0) ? pixel_t'(pix_counter) : pixel_t'($urandom);
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        pix_mem[acc_idx % NPIX] = pix_data;
        acc_idx++;
        sent++;
        if (pix_mode == 0) pix_counter++;
      end
      @(posedge clk);
      #1;
      cycles++;
      phase = ~phase;
    end
    pix_valid = 1'b0;
    checkOutput("pixels_accepted", 64'(sent), 64'(n));
  endtask

  task automatic waitFrames(input int target, input int budget);
    int c;
    c = 0;
    while (fd_total < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("frame_done_reached", 64'(fd_total >= target), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input int budget);
    int c;
    c = 0;
    @(negedge clk);
    while (!pix_ready && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("ready_returned", 64'(pix_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int edges);
    reset = 1'b1;
    pix_valid = 1'b0;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("rst_en", 64'(en), 64'd0);
    checkOutput("rst_pix_ready", 64'(pix_ready), 64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst_patch_row", 64'(patch_row), 64'd0);
    checkOutput("rst_patch_col", 64'(patch_col), 64'd0);
    checkOutput("rst_patch_cache_clear", 64'(patch_cache == '0), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_idx = 0;
    tile_idx = 0;
    nonidle_since_en = 1'b1;
    have_last_en = 1'b0;
    fd_mark = -1;
    @(negedge clk);
    checkOutput("ready_low_after_release", 64'(pix_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("ready_rises", 64'(pix_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs [7];
    int en_base, fd_base, held_bad;
    pixel_t first_pix;

    vecs[0] = '{"t00_00", 0, 0, 0, 24'd0,   0, 0};
    vecs[1] = '{"t00_24", 0, 2, 4, 24'd36,  0, 0};
    vecs[2] = '{"t01_00", 1, 0, 0, 24'd8,   0, 1};
    vecs[3] = '{"t01_77", 1, 7, 7, 24'd127, 0, 1};
    vecs[4] = '{"t10_00", 2, 0, 0, 24'd128, 1, 0};
    vecs[5] = '{"t10_35", 2, 3, 5, 24'd181, 1, 0};
    vecs[6] = '{"t11_77", 3, 7, 7, 24'd255, 1, 1};

    doReset(2);

    $display("[TB] frame of counting pixels, patchifier busy 10 cycles");
    pix_mode = 0;
    pix_counter = 0;
    pf_hold = 10;
    cap_on = 1'b1;
    en_base = en_total;
    fd_base = fd_total;
    applyStimulus(NPIX, 0, 6000);
    waitFrames(fd_base + 1, 2000);
    cap_on = 1'b0;
    checkOutput("frame1_en_pulses", 64'(en_total - en_base), 64'd4);
    checkOutput("frame1_frame_done", 64'(fd_total - fd_base), 64'd1);
    checkOutput("frame1_captured", 64'(cap_tile.size()), 64'd4);
    if (cap_tile.size() >= 4) begin
      for (int k = 0; k < 7; k++) begin
        checkOutput({vecs[k].name, "_pix"},
                    64'(cap_tile[vecs[k].tile_num][vecs[k].i][vecs[k].j]), 64'(vecs[k].exp_pix));
        checkOutput({vecs[k].name, "_row"}, 64'(cap_row[vecs[k].tile_num]), 64'(vecs[k].exp_row));
        checkOutput({vecs[k].name, "_col"}, 64'(cap_col[vecs[k].tile_num]), 64'(vecs[k].exp_col));
      end
    end

    $display("[TB] band with toggling pix_valid");
    pix_mode = 1;
    fd_base = fd_total;
    applyStimulus(PATCH_SIZE * W, 1, 2000);
    @(negedge clk);
    checkOutput("band_done_ready_low", 64'(pix_ready), 64'd0);
    @(posedge clk);
    #1;
    waitReady(200);

    $display("[TB] patchifier held busy while tile is pending");
    pf_auto = 1'b0;
    pf_state = PF_PROCESSING;
    applyStimulus(PATCH_SIZE * W, 0, 1000);
    held_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (en !== 1'b0 || pix_ready !== 1'b0) held_bad++;
      @(posedge clk);
      #1;
    end
    checkOutput("en_held_while_busy", 64'(held_bad), 64'd0);
    pf_cnt = 0;
    pf_state = PF_IDLE;
    pf_auto = 1'b1;
    @(negedge clk);
    checkOutput("en_on_first_idle", 64'(en), 64'd1);
    @(posedge clk);
    #1;
    waitFrames(fd_base + 1, 2000);

    $display("[TB] reset in the middle of band 0, then two back-to-back frames");
    pf_hold = 1;
    applyStimulus(70, 0, 500);
    doReset(1);
    cap_on = 1'b1;
    cap_tile.delete();
    cap_row.delete();
    cap_col.delete();
    en_base = en_total;
    fd_base = fd_total;
    applyStimulus(NPIX, 0, 6000);
    first_pix = pix_mem[0];
    applyStimulus(NPIX, 0, 6000);
    waitFrames(fd_base + 2, 2000);
    cap_on = 1'b0;
    checkOutput("b2b_en_pulses", 64'(en_total - en_base), 64'd8);
    checkOutput("b2b_frame_done", 64'(fd_total - fd_base), 64'd2);
    if (cap_tile.size() >= 1)
      checkOutput("first_post_reset_pixel", 64'(cap_tile[0][0][0]), 64'(first_pix));
    else
      checkOutput("first_post_reset_tile_seen", 64'(cap_tile.size()), 64'd1);

    $display("[TB] random valid, random patchifier latency incl. illegal 01 state");
    pf_rand = 1'b1;
    fd_base = fd_total;
    applyStimulus(NPIX, 2, 8000);
    waitFrames(fd_base + 1, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
